mul_operand_issuer: RTL and testbench
=====================================

// Module: mul_operand_issuer
// PURPOSE
//  Transmit end of the multiplier-stage input handshake: buffers up to DEPTH half-float
//  operand pairs (A,B), then on start issues them in address order to the multiplier stage
//  via srcReady/readyForInput. Observes the multiplier's result handshake to count returned
//  products; pulses done once all issued products have been consumed downstream.
// PARAMETERS
//  DATA_W  16  operand width (IEEE half: 1 sign, 5 exp, 10 mantissa); passed through untouched
//  DEPTH   16  number of operand-pair slots
//  AW      4   address width, clog2(DEPTH)
// PORTS
//  clk              in   1       single clock, all logic on rising edge
//  rst              in   1       asynchronous, active-high reset
//  wr_en            in   1       load operand pair into slot wr_addr (accepted only when !busy)
//  wr_addr          in   AW      slot index
//  wr_a             in   DATA_W  operand A for slot
//  wr_b             in   DATA_W  operand B for slot
//  start            in   1       begin issuing slots 0..len-1 (accepted only when !busy)
//  len              in   AW+1    pair count, 0..DEPTH (sampled with start)
//  busy             out  1       high from accepted start until done pulse inclusive
//  done             out  1       one-cycle pulse: all len products returned
//  mul_srcReady     out  1       operand pair valid toward multiplier
//  mul_readyForInput in  1       multiplier accepts a pair this cycle
//  mul_A            out  DATA_W  operand A (registered)
//  mul_B            out  DATA_W  operand B (registered)
//  mul_outputReadyEn in  1       multiplier result valid (observe only)
//  mul_destReady    in   1       downstream accepts result (observe only)
// BEHAVIOUR
//  Reset: busy=0, done=0, mul_srcReady=0, mul_A=mul_B=0, counters=0, state=IDLE.
//   Operand storage is not reset. Reset mid-operation aborts; no done pulse.
//  Issue transfer: rising edge with mul_srcReady & mul_readyForInput both high.
//  Return event: rising edge with mul_outputReadyEn & mul_destReady both high.
//  Handshake rule: once mul_srcReady rises, mul_srcReady, mul_A and mul_B stay stable until
//   the transfer edge; no retraction. Next pair is presented on the cycle after the transfer
//   edge, so throughput is 1 pair/cycle when readyForInput is held high.
//  FSM:
//   IDLE:  start & len!=0 -> ISSUE; load slot 0 into mul_A/B, mul_srcReady=1 on the next cycle.
//          start & len==0 -> DONE (done pulse next cycle, nothing issued).
//          Return events in IDLE are ignored.
//   ISSUE: on each transfer, issue_cnt++; if issue_cnt+1==len, drop mul_srcReady -> WAIT;
//          else load slot issue_cnt+1.
//   WAIT:  mul_srcReady=0; when ret_cnt reaches len -> DONE.
//   DONE:  done=1, busy=1 for exactly one cycle -> IDLE; counters cleared.
//  ret_cnt counts return events in ISSUE and WAIT. A return coinciding with the last
//   transfer is counted. ISSUE -> DONE directly if ret_cnt==len occurs at that edge.
//  ret_cnt saturates at len; extra returns are ignored.
//  busy: set on the edge that accepts start; cleared on the edge leaving DONE.
//  start while busy: ignored. wr_en while busy: ignored; storage unchanged.
//   wr_en with start in the same IDLE cycle: write completes, and slot contents are read
//   the following cycle.
//  len>DEPTH: clamped to DEPTH.
//  Latency: start edge -> mul_srcReady high 1 cycle later; last return edge -> done 1 cycle later.
// TESTING
//  1) Load slot0 A=0x57B7 B=0xD7B7, start len=1, ready=1, return 3 cycles later
//     -> one transfer of 0x57B7/0xD7B7, then done pulse 1 cycle after the return, busy low after.
//  2) Load 4 pairs, ready held 1, returns immediate
//     -> transfers on 4 consecutive edges in order 0..3; done once.
//  3) Load 3 pairs, readyForInput toggled 0,0,1,0,1,1
//     -> srcReady/A/B stable across stalls; exactly 3 transfers; no slot skipped or duplicated.
//  4) start len=0 -> done pulse 1 cycle later; mul_srcReady never high.
//  5) start and wr_en pulsed mid-ISSUE -> both ignored; original sequence and operand values unchanged.
//  6) rst asserted during WAIT with 1 return outstanding
//     -> all outputs 0 immediately (async), no done pulse; new start len=2 runs cleanly.

Source files
------------

// File: rtl/mul_operand_issuer.sv
// mul_operand_issuer
//   Buffers up to DEPTH half-float operand pairs and, on start, issues slots 0..len-1
//   in order to the multiplier over a valid/ready handshake (mul_srcReady /
//   mul_readyForInput). It watches the multiplier's result handshake
//   (mul_outputReadyEn & mul_destReady) to count returned products, and pulses done
//   once all len products have been consumed downstream.
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   wr_en/wr_addr/wr_a/wr_b
//                      operand-pair load, accepted only while idle (!busy)
//   start, len         begin issuing len pairs (clamped to DEPTH), accepted only while idle
//   busy, done         run in progress; one-cycle completion pulse
//   mul_srcReady, mul_A, mul_B, mul_readyForInput
//                      operand handshake toward the multiplier
//   mul_outputReadyEn, mul_destReady
//                      result handshake, observed only
module mul_operand_issuer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              start,
    input  logic [AW:0]       len,
    output logic              busy,
    output logic              done,
    output logic              mul_srcReady,
    input  logic              mul_readyForInput,
    output logic [DATA_W-1:0] mul_A,
    output logic [DATA_W-1:0] mul_B,
    input  logic              mul_outputReadyEn,
    input  logic              mul_destReady
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } stateT;

    stateT state;

    logic [DATA_W-1:0] memA [DEPTH];
    logic [DATA_W-1:0] memB [DEPTH];

    logic [CW-1:0] lenReg;
    logic [CW-1:0] issueCnt;
    logic [CW-1:0] retCnt;

    logic          writeOk;
    logic          xfer;
    logic          retEv;
    logic [CW-1:0] lenClamp;
    logic [CW-1:0] issueNext;
    logic [CW-1:0] retNext;
    logic [DATA_W-1:0] firstA;
    logic [DATA_W-1:0] firstB;

    // Operand storage: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (writeOk) begin
            memA[wr_addr] <= wr_a;
            memB[wr_addr] <= wr_b;
        end
    end

    always_comb begin
        writeOk   = wr_en & ~busy;
        xfer      = mul_srcReady & mul_readyForInput;
        // Returns only count while a run is active and saturate at len.
        retEv     = mul_outputReadyEn & mul_destReady &
                    ((state == ISSUE) | (state == WAIT)) & (retCnt < lenReg);
        lenClamp  = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
        issueNext = issueCnt + CW'(1);
        retNext   = retCnt + CW'(retEv);
        // A write to slot 0 in the same cycle as start must be what gets issued first.
        firstA    = (writeOk && (wr_addr == '0)) ? wr_a : memA[0];
        firstB    = (writeOk && (wr_addr == '0)) ? wr_b : memB[0];
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mul_srcReady <= 1'b0;
            mul_A        <= '0;
            mul_B        <= '0;
            lenReg       <= '0;
            issueCnt     <= '0;
            retCnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        lenReg   <= lenClamp;
                        issueCnt <= '0;
                        retCnt   <= '0;
                        if (lenClamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            mul_srcReady <= 1'b1;
                            mul_A        <= firstA;
                            mul_B        <= firstB;
                        end
                    end
                end
                ISSUE: begin
                    retCnt <= retNext;
                    // Operands only change on a transfer edge, so a stalled pair never moves.
                    if (xfer) begin
                        issueCnt <= issueNext;
                        if (issueNext == lenReg) begin
                            mul_srcReady <= 1'b0;
                            if (retNext == lenReg) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            mul_A <= memA[AW'(issueNext)];
                            mul_B <= memB[AW'(issueNext)];
                        end
                    end
                end
                WAIT: begin
                    retCnt <= retNext;
                    if (retNext == lenReg) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    issueCnt <= '0;
                    retCnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_operand_issuer.sv
module tb_mul_operand_issuer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_b;
    logic              start;
    logic [AW:0]       len;
    logic              busy;
    logic              done;
    logic              mul_srcReady;
    logic              mul_readyForInput;
    logic [DATA_W-1:0] mul_A;
    logic [DATA_W-1:0] mul_B;
    logic              mul_outputReadyEn;
    logic              mul_destReady;

    mul_operand_issuer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_a              (wr_a),
        .wr_b              (wr_b),
        .start             (start),
        .len               (len),
        .busy              (busy),
        .done              (done),
        .mul_srcReady      (mul_srcReady),
        .mul_readyForInput (mul_readyForInput),
        .mul_A             (mul_A),
        .mul_B             (mul_B),
        .mul_outputReadyEn (mul_outputReadyEn),
        .mul_destReady     (mul_destReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int xferCount    = 0;
    int doneCount    = 0;
    int srcHighCount = 0;

    logic [DATA_W-1:0]   modelA [DEPTH];
    logic [DATA_W-1:0]   modelB [DEPTH];
    logic [2*DATA_W-1:0] expQ [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRet(input logic v);
        mul_outputReadyEn = v;
        mul_destReady     = v;
    endtask

    // Scoreboard monitor: compares each transfer against the expected queue and checks
    // that a stalled pair is held unchanged.
    task automatic monitor();
        logic stall;
        logic [DATA_W-1:0] pa;
        logic [DATA_W-1:0] pb;
        logic [2*DATA_W-1:0] exp;
        stall = 1'b0;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (mul_srcReady) srcHighCount++;
                if (done) doneCount++;
                if (stall) begin
                    total++;
                    if (mul_srcReady !== 1'b1 || mul_A !== pa || mul_B !== pb) begin
                        bad++;
                        $display("FAIL stall_hold: got srcReady=%0b A=%h B=%h, required 1 A=%h B=%h",
                                 mul_srcReady, mul_A, mul_B, pa, pb);
                    end
                end
                if (mul_srcReady && mul_readyForInput) begin
                    xferCount++;
                    total++;
                    if (expQ.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_xfer: got A=%h B=%h, required no transfer", mul_A, mul_B);
                    end else begin
                        exp = expQ.pop_front();
                        if ({mul_A, mul_B} !== exp) begin
                            bad++;
                            $display("FAIL xfer_data: got A=%h B=%h, required A=%h B=%h",
                                     mul_A, mul_B, exp[2*DATA_W-1:DATA_W], exp[DATA_W-1:0]);
                        end
                    end
                end
                stall = mul_srcReady && !mul_readyForInput;
                pa = mul_A;
                pb = mul_B;
            end
        end
    endtask

    task automatic loadPair(input int addr, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_a    = a;
        wr_b    = b;
        modelA[addr] = a;
        modelB[addr] = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic startRun(input int l);
        int n;
        n = (l > int'(DEPTH)) ? int'(DEPTH) : l;
        start = 1'b1;
        len   = (AW+1)'(l);
        for (int i = 0; i < n; i++) expQ.push_back({modelA[i], modelB[i]});
        tick();
        start = 1'b0;
    endtask

    // Polls for the done pulse with a cycle budget, then steps past the DONE cycle.
    task automatic waitDone(input string name, input int maxCyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles, required a done pulse", name, maxCyc);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_after: got busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, mul_srcReady} !== 3'b000 || mul_A !== '0 || mul_B !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b src=%0b A=%h B=%h, required all 0",
                     busy, done, mul_srcReady, mul_A, mul_B);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({busy, done, mul_srcReady} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: got busy=%0b done=%0b src=%0b, required 0 0 0", busy, done, mul_srcReady);
        end
    endtask

    task automatic test_single();
        int d0;
        d0 = doneCount;
        mul_readyForInput = 1'b1;
        loadPair(0, 16'h57B7, 16'hD7B7);
        startRun(1);
        total++;
        if (busy !== 1'b1 || mul_srcReady !== 1'b1 || mul_A !== 16'h57B7 || mul_B !== 16'hD7B7) begin
            bad++;
            $display("FAIL single_issue: got busy=%0b src=%0b A=%h B=%h, required 1 1 57b7 d7b7",
                     busy, mul_srcReady, mul_A, mul_B);
        end
        tick();
        total++;
        if (mul_srcReady !== 1'b0) begin
            bad++;
            $display("FAIL single_src_drop: got src=%0b, required 0", mul_srcReady);
        end
        tick();
        tick();
        setRet(1'b1);
        tick();
        setRet(1'b0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_done: got done=%0b busy=%0b, required 1 1", done, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got done=%0b busy=%0b, required 0 0", done, busy);
        end
        total++;
        if (doneCount - d0 !== 1) begin
            bad++;
            $display("FAIL single_done_count: got %0d, required 1", doneCount - d0);
        end
    endtask

    task automatic test_burst();
        int d0;
        d0 = doneCount;
        for (int i = 0; i < 4; i++) loadPair(i, 16'h3C00 + 16'(i), 16'hC000 + 16'(i * 3));
        mul_readyForInput = 1'b1;
        setRet(1'b1);
        startRun(4);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mul_srcReady !== 1'b1 || mul_A !== modelA[k] || mul_B !== modelB[k]) begin
                bad++;
                $display("FAIL burst_slot%0d: got src=%0b A=%h B=%h, required 1 A=%h B=%h",
                         k, mul_srcReady, mul_A, mul_B, modelA[k], modelB[k]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || mul_srcReady !== 1'b0) begin
            bad++;
            $display("FAIL burst_done: got done=%0b src=%0b, required 1 0", done, mul_srcReady);
        end
        setRet(1'b0);
        tick();
        total++;
        if (busy !== 1'b0 || doneCount - d0 !== 1) begin
            bad++;
            $display("FAIL burst_once: got busy=%0b dones=%0d, required 0 1", busy, doneCount - d0);
        end
    endtask

    task automatic test_stall();
        int x0;
        logic pat [6];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) loadPair(i, 16'h4000 + 16'(i * 17), 16'h8800 + 16'(i * 5));
        mul_readyForInput = 1'b0;
        setRet(1'b0);
        x0 = xferCount;
        startRun(3);
        for (int i = 0; i < 6; i++) begin
            mul_readyForInput = pat[i];
            tick();
        end
        mul_readyForInput = 1'b0;
        total++;
        if (xferCount - x0 !== 3 || expQ.size() !== 0 || mul_srcReady !== 1'b0) begin
            bad++;
            $display("FAIL stall_count: got xfers=%0d pending=%0d src=%0b, required 3 0 0",
                     xferCount - x0, expQ.size(), mul_srcReady);
        end
        setRet(1'b1);
        tick();
        tick();
        tick();
        setRet(1'b0);
        waitDone("stall", 10);
    endtask

    task automatic test_zero_len();
        int s0;
        s0 = srcHighCount;
        startRun(0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || mul_srcReady !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: got done=%0b busy=%0b src=%0b, required 1 1 0", done, busy, mul_srcReady);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || srcHighCount !== s0) begin
            bad++;
            $display("FAIL zero_idle: got done=%0b busy=%0b srcCycles=%0d, required 0 0 0",
                     done, busy, srcHighCount - s0);
        end
    endtask

    task automatic test_ignore_busy();
        int x0;
        for (int i = 0; i < 4; i++) loadPair(i, 16'h1100 + 16'(i), 16'h2200 + 16'(i));
        mul_readyForInput = 1'b0;
        setRet(1'b0);
        x0 = xferCount;
        startRun(4);
        tick();
        start   = 1'b1;
        len     = 5'd2;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_a    = 16'hFFFF;
        wr_b    = 16'hEEEE;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        mul_readyForInput = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mul_readyForInput = 1'b0;
        total++;
        if (xferCount - x0 !== 4 || expQ.size() !== 0) begin
            bad++;
            $display("FAIL ignore_count: got xfers=%0d pending=%0d, required 4 0", xferCount - x0, expQ.size());
        end
        setRet(1'b1);
        waitDone("ignore", 10);
        setRet(1'b0);
        // Storage must still hold the original slot 1 pair.
        mul_readyForInput = 1'b1;
        setRet(1'b1);
        startRun(2);
        waitDone("ignore_reread", 10);
        setRet(1'b0);
    endtask

    task automatic test_reset_mid();
        int x0;
        int d0;
        loadPair(0, 16'h5555, 16'h6666);
        loadPair(1, 16'h7777, 16'h0123);
        mul_readyForInput = 1'b1;
        setRet(1'b0);
        x0 = xferCount;
        startRun(2);
        tick();
        tick();
        setRet(1'b1);
        tick();
        setRet(1'b0);
        tick();
        d0 = doneCount;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, mul_srcReady} !== 3'b000 || mul_A !== '0 || mul_B !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got busy=%0b done=%0b src=%0b A=%h B=%h, required all 0",
                     busy, done, mul_srcReady, mul_A, mul_B);
        end
        total++;
        if (xferCount - x0 !== 2) begin
            bad++;
            $display("FAIL rstmid_xfers: got %0d, required 2", xferCount - x0);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (doneCount !== d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_no_done: got dones=%0d busy=%0b, required 0 0", doneCount - d0, busy);
        end
        // Fresh run where slot 0 is rewritten in the same cycle as start.
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_a    = 16'hABCD;
        wr_b    = 16'h1357;
        modelA[0] = 16'hABCD;
        modelB[0] = 16'h1357;
        setRet(1'b1);
        startRun(2);
        wr_en = 1'b0;
        waitDone("rstmid_rerun", 10);
        setRet(1'b0);
    endtask

    task automatic test_clamp();
        int x0;
        for (int i = 0; i < int'(DEPTH); i++) loadPair(i, 16'(i * 257), 16'(16'hF000 - 16'(i)));
        mul_readyForInput = 1'b1;
        setRet(1'b1);
        x0 = xferCount;
        startRun(20);
        waitDone("clamp", 40);
        setRet(1'b0);
        total++;
        if (xferCount - x0 !== int'(DEPTH) || expQ.size() !== 0) begin
            bad++;
            $display("FAIL clamp_count: got xfers=%0d pending=%0d, required %0d 0",
                     xferCount - x0, expQ.size(), DEPTH);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_a = '0;
        wr_b = '0;
        start = 1'b0;
        len = '0;
        mul_readyForInput = 1'b0;
        mul_outputReadyEn = 1'b0;
        mul_destReady = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_zero_len();
        test_ignore_busy();
        test_reset_mid();
        test_clamp();
        tick();
        total++;
        if (expQ.size() !== 0) begin
            bad++;
            $display("FAIL final_queue: got %0d pending transfers, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
